// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between the requesters / result consumer and
// mult_share_arbiter.
//   req_valid[N_REQ]       request valid, one bit per requester
//   req_a/req_b            operand pairs, requester i at [i*WIDTH +: WIDTH]
//   req_ready[N_REQ]       one-hot grant back to the requesters
//   res_valid/res_ready    result handshake
//   res_p                  full-width product
//   res_id                 index of the requester that issued the operands
// The arbiter uses the slave modport; the requester/consumer side uses master.
interface mult_share_arbiter_if #(
    parameter int WIDTH = 2,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) ();
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*WIDTH-1:0]     res_p;
    logic [ID_W-1:0]        res_id;

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, res_id
    );

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, res_id
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one combinational multiplier among N_REQ
// requesters. Two-stage pipeline: S1 holds the granted operand pair, S2 holds
// the registered product and requester ID behind a backpressured result port.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       request/result handshake bundle (slave side)
//   busy      an operation is in S1 or S2
//   op_count  completed result handshakes, wraps at 2^16
module mult_share_arbiter #(
    parameter int WIDTH = 2,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_share_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [15:0]          op_count
);

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic [ID_W-1:0]      r_s1_id;

    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_res_p;
    logic [ID_W-1:0]      r_res_id;

    logic [ID_W-1:0]      r_rr_ptr;
    logic [15:0]          r_op_count;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_found;
    logic                 w_xfer;
    logic [ID_W-1:0]      w_grant_id;
    logic [ID_W-1:0]      w_rr_next;
    logic [N_REQ-1:0]     w_grant;
    logic [2*WIDTH-1:0]   w_p;

    assign w_s2_adv = !r_res_valid || bus.res_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found    = 1'b1;
                w_grant_id = ID_W'(idx);
            end
        end
    end

    // Gated by rst_n so no grant is shown while reset is asserted.
    assign w_xfer    = w_s1_adv && w_found && rst_n;
    assign w_grant   = w_xfer ? (N_REQ'(1) << w_grant_id) : '0;
    assign w_rr_next = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

    // Shared multiplier datapath: unsigned, full-width product.
    assign w_p = (2*WIDTH)'(r_s1_a) * (2*WIDTH)'(r_s1_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_rr_ptr   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_a   <= bus.req_a[w_grant_id*WIDTH +: WIDTH];
                r_s1_b   <= bus.req_b[w_grant_id*WIDTH +: WIDTH];
                r_s1_id  <= w_grant_id;
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_p     <= '0;
            r_res_id    <= '0;
        end else if (w_s2_adv) begin
            r_res_valid <= r_s1_valid;
            r_res_p     <= w_p;
            r_res_id    <= r_s1_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (r_res_valid && bus.res_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.res_valid = r_res_valid;
    assign bus.res_p     = r_res_p;
    assign bus.res_id    = r_res_id;
    assign busy          = r_s1_valid | r_res_valid;
    assign op_count      = r_op_count;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter (WIDTH=2, N_REQ=4).
// Reference: a queue of accepted operations in acceptance order, with a flag
// telling whether the oldest one has reached the result register.
module tb_mult_share_arbiter;
    localparam int WIDTH = 2;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] op_count;

    mult_share_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    mult_share_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // reference model state
    int q_id[$];
    int q_a[$];
    int q_b[$];
    bit m_head_s2;
    int m_rr;
    int m_cnt;

    // handshakes observed at the result port, for sequence checks
    int log_p[$];
    int log_id[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (!(q_id.size() < 2 || bus.res_ready)) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (m_rr + k) % N_REQ;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    int  mg;
    bit  m_pop;
    bit  m_s2_free;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_id.delete(); q_a.delete(); q_b.delete();
            m_head_s2 = 1'b0;
            m_rr      = 0;
            m_cnt     = 0;
        end else begin
            mg        = model_grant();
            m_pop     = m_head_s2 && bus.res_ready;
            m_s2_free = !m_head_s2 || bus.res_ready;
            if (m_pop) begin
                void'(q_id.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front());
                m_head_s2 = 1'b0;
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (q_id.size() > 0 && !m_head_s2 && m_s2_free) m_head_s2 = 1'b1;
            if (mg >= 0) begin
                q_id.push_back(mg);
                q_a.push_back(int'(bus.req_a[mg*WIDTH +: WIDTH]));
                q_b.push_back(int'(bus.req_b[mg*WIDTH +: WIDTH]));
                m_rr = (mg + 1) % N_REQ;
            end
        end
    end

    int         cg;
    logic [3:0] c_er;
    bit         c_rv;
    always @(negedge clk) begin
        if (chk_en) begin
            cg   = model_grant();
            c_er = (cg >= 0) ? 4'(1 << cg) : 4'b0000;
            c_rv = rst_n && q_id.size() > 0 && m_head_s2;
            chk("req_ready", 32'(bus.req_ready), 32'(c_er));
            chk("res_valid", 32'(bus.res_valid), 32'(c_rv));
            chk("busy",      32'(busy),          32'(q_id.size() > 0));
            chk("op_count",  32'(op_count),      32'(m_cnt));
            if (c_rv) begin
                chk("res_p",  32'(bus.res_p),  32'(q_a[0] * q_b[0]));
                chk("res_id", 32'(bus.res_id), 32'(q_id[0]));
            end else if (!rst_n) begin
                chk("rst_res_p",  32'(bus.res_p),  32'd0);
                chk("rst_res_id", 32'(bus.res_id), 32'd0);
            end
            if (rst_n && bus.res_valid && bus.res_ready) begin
                log_p.push_back(int'(bus.res_p));
                log_id.push_back(int'(bus.res_id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic rand_ops();
        bus.req_a = 8'($urandom);
        bus.req_b = 8'($urandom);
    endtask

    int rr_p[4];
    initial begin
        rr_p[0] = 2; rr_p[1] = 3; rr_p[2] = 6; rr_p[3] = 3;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        #2;
        chk_en = 1'b1;

        // reset with random requests
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 4'($urandom);
            rand_ops();
            bus.res_ready = 1'($urandom);
            step();
        end
        @(negedge clk);
        chk("rst_ready_lit", 32'(bus.req_ready), 32'd0);
        chk("rst_valid_lit", 32'(bus.res_valid), 32'd0);

        // single requester, 3*3, first grant right after release
        step();
        bus.req_valid = 4'b0001;
        set_req(0, 3, 3);
        bus.res_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant_lit", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("single_busy_lit", 32'(busy), 32'd1);
        chk("single_rv0_lit",  32'(bus.res_valid), 32'd0);
        step();
        @(negedge clk);
        chk("single_rv_lit", 32'(bus.res_valid), 32'd1);
        chk("single_p_lit",  32'(bus.res_p), 32'd9);
        chk("single_id_lit", 32'(bus.res_id), 32'd0);
        chk("single_cnt0_lit", 32'(op_count), 32'd0);
        step();
        @(negedge clk);
        chk("single_cnt1_lit", 32'(op_count), 32'd1);

        // round robin with a 3-cycle result stall
        step();
        rst_n = 1'b0;
        step();
        log_p.delete(); log_id.delete();
        set_req(0, 1, 2); set_req(1, 1, 3); set_req(2, 2, 3); set_req(3, 3, 1);
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        rst_n = 1'b1;
        repeat (8) step();
        bus.res_ready = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("stall_ready_lit", 32'(bus.req_ready), 32'd0);
        chk("stall_busy_lit",  32'(busy), 32'd1);
        step();
        bus.res_ready = 1'b1;
        repeat (8) step();
        chk("rr_log_len", 32'(log_p.size() >= 12), 32'd1);
        for (int i = 0; i < log_p.size(); i++) begin
            chk("rr_seq_p",  32'(log_p[i]),  32'(rr_p[i % 4]));
            chk("rr_seq_id", 32'(log_id[i]), 32'(i % 4));
        end

        // reset with both stages full
        bus.res_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #2;
        chk("midrst_rv_lit",   32'(bus.res_valid), 32'd0);
        chk("midrst_busy_lit", 32'(busy), 32'd0);
        step();
        step();
        bus.req_valid = 4'b1010;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_grant_lit", 32'(bus.req_ready), 32'd2);
        chk("midrst_cnt_lit",   32'(op_count), 32'd0);
        chk("midrst_rv2_lit",   32'(bus.res_valid), 32'd0);
        bus.res_ready = 1'b1;
        repeat (4) step();
        bus.req_valid = 4'b0000;
        repeat (3) step();

        // exhaustive operands from requester 2
        rst_n = 1'b0;
        step();
        log_p.delete(); log_id.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.req_valid = 4'b0100;
            set_req(2, k / 4, k % 4);
            step();
        end
        bus.req_valid = 4'b0000;
        repeat (4) step();
        chk("exh_log_len", 32'(log_p.size()), 32'd16);
        for (int k = 0; k < log_p.size() && k < 16; k++) begin
            chk("exh_p",  32'(log_p[k]),  32'((k / 4) * (k % 4)));
            chk("exh_id", 32'(log_id[k]), 32'd2);
        end
        @(negedge clk);
        chk("exh_cnt_lit", 32'(op_count), 32'd16);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.req_valid = 4'($urandom);
            rand_ops();
            bus.res_ready = (($urandom % 4) != 0);
            if ((i % 97) > 90) bus.res_ready = 1'b0;
            step();
        end
        bus.req_valid = 4'b0000;
        bus.res_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
